sharpen_step_ctrl: RTL
======================

# sharpen_step_ctrl

Sequencer for the image-sharpening extension of the DLX processor. On a START pulse it walks every output pixel of an IMG_H x IMG_W image in raster order. For each pixel it issues nine 3x3 kernel tap reads with edge-clamped source coordinates and drives accumulator clear/enable strobes. It then waits out the MAC pipeline latency and hands the result to write-back with a req/ack handshake. It owns the step/tap sequencing that the kernel datapath and step counters consume.

## Interface
Parameters:
- IMG_W, 16, image width in pixels (>= 2)
- IMG_H, 16, image height in pixels (>= 2)
- CW, 5, coordinate width; 2^CW >= max(IMG_W, IMG_H)
- ACC_LAT, 2, MAC pipeline drain cycles between last tap accept and write-back (0..7)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  start pulse; honoured only in IDLE
- ABORT  in  1  abort; highest priority, any state
- MEM_ACK  in  1  tap read data valid this cycle
- WB_ACK  in  1  write-back accepted this cycle
- MEM_REQ  out  1  tap read request
- ROW, COL  out  CW each  current output pixel
- TAP  out  4  kernel tap index 0..8
- RD_ROW, RD_COL  out  CW each  clamped tap source coordinate
- ACC_CLR  out  1  clear accumulator
- ACC_EN  out  1  accumulate current tap data
- WB_REQ  out  1  write-back request
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, FIN. RST low: IDLE. All registers and outputs are 0.
- IDLE: START=1 -> FETCH, ROW=COL=TAP=0.
- FETCH: MEM_REQ=1.
  - MEM_ACK=1 with TAP<8 -> TAP+1, stay in FETCH. Back-to-back requests are allowed.
  - MEM_ACK=1 with TAP=8 -> DRAIN, or WRITE directly if ACC_LAT=0.
  - MEM_ACK=0 -> hold all outputs.
- ACC_CLR=1 in FETCH when TAP=0, for every cycle of that tap until acked. ACC_EN = (state==FETCH) & MEM_ACK, combinational.
- Tap offsets: dr = TAP/3 - 1, dc = TAP%3 - 1.
- RD_ROW = clamp(ROW+dr, 0, IMG_H-1); RD_COL = clamp(COL+dc, 0, IMG_W-1). Evaluate in CW+1-bit signed; no wrap-around.
- RD_ROW/RD_COL are 0 outside FETCH.
- DRAIN: down-counter loaded with ACC_LAT; -> WRITE when it expires (exactly ACC_LAT cycles).
- WRITE: WB_REQ=1 until WB_ACK. On WB_ACK:
  - Last pixel (ROW=IMG_H-1, COL=IMG_W-1) -> FIN.
  - Otherwise advance: COL+1; if COL=IMG_W-1 then COL=0 and ROW+1. Then -> FETCH with TAP=0.
- FIN: DONE=1 for one cycle -> IDLE. ROW/COL/TAP return to 0.
- ABORT=1 in any state -> IDLE next cycle, all outputs 0, no DONE. ABORT beats START, MEM_ACK and WB_ACK in the same cycle.
- START outside IDLE is ignored. START and ABORT together in IDLE: stay in IDLE.
- MEM_ACK outside FETCH and WB_ACK outside WRITE are ignored.

## Timing
- All outputs are registered except ACC_EN.
- START sampled at edge 0 -> MEM_REQ=1, ACC_CLR=1 in cycle 1.
- With zero-wait acks, each pixel takes 9 + ACC_LAT + 1 cycles. Pixel k's first FETCH is at cycle 1 + k*(10+ACC_LAT).
- 16x16 image, ACC_LAT=2:
  - Last WB_ACK at cycle 3072.
  - DONE=1 at cycle 3073.
  - IDLE (BUSY=0) at cycle 3074.
- RST deassertion mid-frame resumes in IDLE only. No state is retained.

## Test plan
- Full frame, 16x16, ACC_LAT=2, MEM_ACK/WB_ACK tied 1, START at cycle 0 -> exactly 2304 ACC_EN pulses, 256 ACC_CLR cycles, 256 WB handshakes, DONE only at cycle 3073, BUSY low from 3074.
- Edge clamp:
  - Pixel (0,0): taps 0..8 -> RD (0,0)(0,0)(0,1)(0,0)(0,0)(0,1)(1,0)(1,0)(1,1).
  - Pixel (15,15): tap 8 -> (15,15); tap 0 -> (14,14).
- Row wrap: WB_ACK at (3,15) -> next FETCH at ROW=4, COL=0, TAP=0, ACC_CLR=1.
- Stalls: MEM_ACK low 3 cycles at TAP=4 -> TAP, RD_*, MEM_REQ held, no ACC_EN; WB_ACK delayed 5 cycles -> WB_REQ held 6 cycles, ROW/COL unchanged.
- ACC_LAT=0 and ACC_LAT=7: cycles from TAP=8 ack to WB_REQ rise = 1 and 8 respectively.
- ABORT in DRAIN, and ABORT with WB_ACK in the same cycle -> IDLE next cycle, all outputs 0, no DONE. START in the same cycle as ABORT ignored; a new START then runs from pixel (0,0).
- RST low asynchronously mid-FETCH -> outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/sharpen_step_ctrl_if.sv
// Handshake and tap-address bundle between the sharpen sequencer and its datapath.
// Latency: none, wiring only.
// Backpressure: MEM_ACK stalls tap reads, WB_ACK stalls write-back.
interface sharpen_step_ctrl_if #(
    parameter int CW = 5
);
    logic          START;
    logic          ABORT;
    logic          MEM_ACK;
    logic          WB_ACK;
    logic          MEM_REQ;
    logic [CW-1:0] ROW;
    logic [CW-1:0] COL;
    logic [3:0]    TAP;
    logic [CW-1:0] RD_ROW;
    logic [CW-1:0] RD_COL;
    logic          ACC_CLR;
    logic          ACC_EN;
    logic          WB_REQ;
    logic          BUSY;
    logic          DONE;

    // sequencer side
    modport master (
        input  START, ABORT, MEM_ACK, WB_ACK,
        output MEM_REQ, ROW, COL, TAP, RD_ROW, RD_COL,
               ACC_CLR, ACC_EN, WB_REQ, BUSY, DONE
    );

    // datapath / environment side
    modport slave (
        output START, ABORT, MEM_ACK, WB_ACK,
        input  MEM_REQ, ROW, COL, TAP, RD_ROW, RD_COL,
               ACC_CLR, ACC_EN, WB_REQ, BUSY, DONE
    );
endinterface

// File: rtl/sharpen_step_ctrl.sv
// Raster-order 3x3 sharpen sequencer: nine clamped tap reads, MAC drain, write-back per pixel.
// Latency: 9 + ACC_LAT + 1 cycles per pixel with zero-wait acks; all outputs registered except ACC_EN.
// Backpressure: MEM_ACK low holds the current tap, WB_ACK low holds the write-back request.
module sharpen_step_ctrl #(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int CW      = 5,
    parameter int ACC_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST,
    sharpen_step_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [3:0]    TAP_LAST = 4'd8;
    localparam logic [2:0]    LAT      = 3'(ACC_LAT);

    // Two guard bits so base+1 never wraps even when the image fills the whole coordinate range.
    localparam logic signed [CW+1:0] ROW_LIM = (CW+2)'(IMG_H - 1);
    localparam logic signed [CW+1:0] COL_LIM = (CW+2)'(IMG_W - 1);
    localparam logic signed [CW+1:0] P_ONE   = (CW+2)'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    tap_q, tap_d;
    logic [2:0]    cnt_q, cnt_d;

    logic          mem_req_q, mem_req_d;
    logic [CW-1:0] rd_row_q, rd_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic          acc_clr_q, acc_clr_d;
    logic          wb_req_q, wb_req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [1:0]    rsel_d, csel_d;

    // Kernel tap index -> {row, col} offset selectors, 0/1/2 meaning -1/0/+1.
    function automatic logic [3:0] tap_sel(input logic [3:0] tap);
        logic [3:0] s;
        case (tap)
            4'd0:    s = {2'd0, 2'd0};
            4'd1:    s = {2'd0, 2'd1};
            4'd2:    s = {2'd0, 2'd2};
            4'd3:    s = {2'd1, 2'd0};
            4'd4:    s = {2'd1, 2'd1};
            4'd5:    s = {2'd1, 2'd2};
            4'd6:    s = {2'd2, 2'd0};
            4'd7:    s = {2'd2, 2'd1};
            4'd8:    s = {2'd2, 2'd2};
            default: s = {2'd1, 2'd1};
        endcase
        return s;
    endfunction

    // Offset a coordinate by -1/0/+1 and clamp it into [0, lim].
    function automatic logic [CW-1:0] clamp_add(input logic [CW-1:0]        base,
                                                input logic [1:0]           sel,
                                                input logic signed [CW+1:0] lim);
        logic signed [CW+1:0] off;
        logic signed [CW+1:0] sum;
        logic [CW-1:0]        res;
        case (sel)
            2'd0:    off = -P_ONE;
            2'd2:    off = P_ONE;
            default: off = '0;
        endcase
        sum = $signed({2'b00, base}) + off;
        if (sum[CW+1]) begin
            res = '0;
        end else if (sum > lim) begin
            res = lim[CW-1:0];
        end else begin
            res = sum[CW-1:0];
        end
        return res;
    endfunction

    // State register together with the pixel, tap and drain counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; ABORT overrides every other input.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        if (bus.ABORT) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            tap_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        state_d = S_FETCH;
                        row_d   = '0;
                        col_d   = '0;
                        tap_d   = '0;
                    end
                end
                S_FETCH: begin
                    if (bus.MEM_ACK) begin
                        if (tap_q == TAP_LAST) begin
                            // TAP stays at 8 until the pixel is written back.
                            if (LAT == 3'd0) begin
                                state_d = S_WRITE;
                            end else begin
                                state_d = S_DRAIN;
                                cnt_d   = LAT;
                            end
                        end else begin
                            tap_d = tap_q + 4'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = S_WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_WRITE: begin
                    if (bus.WB_ACK) begin
                        tap_d = '0;
                        if (row_q == ROW_LAST && col_q == COL_LAST) begin
                            state_d = S_FIN;
                            row_d   = '0;
                            col_d   = '0;
                        end else begin
                            state_d = S_FETCH;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + CW'(1);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                    tap_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state so they can be registered.
    always_comb begin
        {rsel_d, csel_d} = tap_sel(tap_d);
        mem_req_d = (state_d == S_FETCH);
        acc_clr_d = (state_d == S_FETCH) && (tap_d == 4'd0);
        wb_req_d  = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
        rd_row_d  = '0;
        rd_col_d  = '0;
        if (state_d == S_FETCH) begin
            rd_row_d = clamp_add(row_d, rsel_d, ROW_LIM);
            rd_col_d = clamp_add(col_d, csel_d, COL_LIM);
        end
    end

    // Output registers; cleared asynchronously with the rest of the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_req_q <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            acc_clr_q <= 1'b0;
            wb_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mem_req_q <= mem_req_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            acc_clr_q <= acc_clr_d;
            wb_req_q  <= wb_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.MEM_REQ = mem_req_q;
    assign bus.ROW     = row_q;
    assign bus.COL     = col_q;
    assign bus.TAP     = tap_q;
    assign bus.RD_ROW  = rd_row_q;
    assign bus.RD_COL  = rd_col_q;
    assign bus.ACC_CLR = acc_clr_q;
    // Accumulate strobe follows the read data valid in the same cycle.
    assign bus.ACC_EN  = (state_q == S_FETCH) && bus.MEM_ACK;
    assign bus.WB_REQ  = wb_req_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;

endmodule
